// File: rtl/fetch_pipe.sv
// Instruction-fetch stage with IF/ID pipeline register for the pipelined LEGv8 datapath.
// Owns the PC, talks to a variable-latency instruction memory and buffers one word while decode stalls.
module fetch_pipe #(
    parameter int              N        = 64,
    parameter logic [N-1:0]    RESET_PC = '0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          PCSrc_M,
    input  logic [N-1:0]  PCBranch_M,
    input  logic          stall_D,
    output logic          imem_req,
    output logic [N-1:0]  imem_addr,
    input  logic [31:0]   imem_rdata,
    input  logic          imem_ready,
    output logic [31:0]   instr_D,
    output logic [N-1:0]  PC_D,
    output logic          valid_D
);

    typedef enum logic [1:0] {IDLE, REQ, KILL} state_t;

    state_t         state, state_n;
    logic [N-1:0]   pc_f, pc_n;
    logic [N-1:0]   redirect_pc, redirect_n;
    logic           hold_valid, hold_valid_n;
    logic [31:0]    hold_instr, hold_instr_n;
    logic [N-1:0]   hold_pc, hold_pc_n;
    logic [31:0]    instr_n;
    logic [N-1:0]   pcd_n;
    logic           valid_n;
    logic [N-1:0]   br_tgt;

    assign br_tgt    = {PCBranch_M[N-1:2], 2'b00};
    assign imem_addr = pc_f;
    // A captured word in the hold buffer blocks new requests until decode drains it.
    assign imem_req  = ((state == REQ) && !hold_valid) || (state == KILL);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            pc_f        <= RESET_PC;
            redirect_pc <= '0;
            hold_valid  <= 1'b0;
            hold_instr  <= '0;
            hold_pc     <= '0;
            instr_D     <= '0;
            PC_D        <= '0;
            valid_D     <= 1'b0;
        end else begin
            state       <= state_n;
            pc_f        <= pc_n;
            redirect_pc <= redirect_n;
            hold_valid  <= hold_valid_n;
            hold_instr  <= hold_instr_n;
            hold_pc     <= hold_pc_n;
            instr_D     <= instr_n;
            PC_D        <= pcd_n;
            valid_D     <= valid_n;
        end
    end

    always_comb begin
        state_n      = state;
        pc_n         = pc_f;
        redirect_n   = redirect_pc;
        hold_valid_n = hold_valid;
        hold_instr_n = hold_instr;
        hold_pc_n    = hold_pc;
        instr_n      = instr_D;
        pcd_n        = PC_D;
        valid_n      = valid_D;

        case (state)
            IDLE: begin
                state_n = REQ;
                if (PCSrc_M) begin
                    pc_n         = br_tgt;
                    instr_n      = '0;
                    valid_n      = 1'b0;
                    hold_valid_n = 1'b0;
                end
            end
            REQ: begin
                if (PCSrc_M) begin
                    instr_n      = '0;
                    valid_n      = 1'b0;
                    hold_valid_n = 1'b0;
                    // An in-flight request must finish before the target can be issued.
                    if (!hold_valid && !imem_ready) begin
                        redirect_n = br_tgt;
                        state_n    = KILL;
                    end else begin
                        pc_n = br_tgt;
                    end
                end else if (hold_valid) begin
                    if (!stall_D) begin
                        instr_n      = hold_instr;
                        pcd_n        = hold_pc;
                        valid_n      = 1'b1;
                        hold_valid_n = 1'b0;
                    end
                end else if (imem_ready) begin
                    pc_n = pc_f + N'(4);
                    if (stall_D) begin
                        hold_instr_n = imem_rdata;
                        hold_pc_n    = pc_f;
                        hold_valid_n = 1'b1;
                    end else begin
                        instr_n = imem_rdata;
                        pcd_n   = pc_f;
                        valid_n = 1'b1;
                    end
                end else if (!stall_D) begin
                    instr_n = '0;
                    pcd_n   = pc_f;
                    valid_n = 1'b0;
                end
            end
            KILL: begin
                instr_n      = '0;
                valid_n      = 1'b0;
                hold_valid_n = 1'b0;
                if (PCSrc_M) begin
                    redirect_n = br_tgt;
                end
                if (imem_ready) begin
                    pc_n    = PCSrc_M ? br_tgt : redirect_pc;
                    state_n = REQ;
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: doc/fetch_pipe.md
Name: fetch_pipe

Overview:
- Instruction-fetch stage plus IF/ID pipeline register for the pipelined LEGv8 datapath.
- Sits directly upstream of decode and drives its instr_D input.
- Owns the PC, issues requests to a variable-latency instruction memory, and buffers one returned instruction while decode is stalled.
- Applies branch redirects coming back from MEM.

Parameters:
N, 64, datapath/PC width in bits
RESET_PC, 0, PC value loaded on reset

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  asynchronous, active-low reset
PCSrc_M  in  1  branch taken, resolved in MEM; redirect request
PCBranch_M  in  N  branch target; bits [1:0] ignored and treated as 00
stall_D  in  1  hazard-unit stall; IF/ID must hold its contents
imem_req  out  1  instruction-memory request valid
imem_addr  out  N  instruction-memory address; equals PC_F
imem_rdata  in  32  instruction word; valid only in a cycle with imem_ready=1
imem_ready  in  1  completes the outstanding request this cycle
instr_D  out  32  instruction to decode
PC_D  out  N  PC of instr_D
valid_D  out  1  instr_D is a real instruction (0 = bubble)

Behaviour:
- Reset (reset=0, asynchronous):
  - PC_F=RESET_PC, state=IDLE, hold_valid=0.
  - instr_D=0, PC_D=0, valid_D=0, imem_req=0.
- States:
  - IDLE: one cycle after reset release, imem_req=0, always goes to REQ.
  - REQ: normal fetching.
  - KILL: a redirect arrived while a request was outstanding.
- Memory protocol:
  - imem_req=1 and imem_addr=PC_F are held stable until imem_ready=1.
  - Completion occurs in the ready cycle. The next request may start in the following cycle.
  - imem_req=1 in REQ when hold_valid=0, and always in KILL. Otherwise 0.
- REQ, ready=1, stall_D=0, PCSrc_M=0:
  - instr_D<=imem_rdata, PC_D<=PC_F, valid_D<=1.
  - PC_F<=PC_F+4, modulo 2^N; wrap is silent.
- REQ, ready=1, stall_D=1:
  - hold_instr<=imem_rdata, hold_pc<=PC_F, hold_valid<=1.
  - PC_F<=PC_F+4.
  - IF/ID unchanged.
- REQ, ready=0, stall_D=0, hold_valid=0: IF/ID loads a bubble (valid_D<=0, instr_D<=0, PC_D<=PC_F).
- hold_valid=1 and stall_D=0 (no redirect): IF/ID loads hold_instr/hold_pc with valid_D<=1, and hold_valid<=0.
- Any stall_D=1 without redirect: IF/ID holds all three outputs.
- Redirect (PCSrc_M=1) has highest priority and overrides stall_D:
  - valid_D<=0, instr_D<=0, and hold_valid<=0.
  - IDLE, or REQ with hold_valid=1, or REQ with ready=1: PC_F<=PCBranch_M; returned data is discarded; state REQ.
  - REQ with ready=0 and hold_valid=0: redirect_pc<=PCBranch_M, state KILL, PC_F unchanged.
  - KILL with PCSrc_M=1 again: redirect_pc overwritten with the newest target.
- KILL:
  - IF/ID outputs bubbles every cycle regardless of stall_D.
  - On imem_ready=1: data discarded, PC_F<=redirect_pc, state REQ.
- Latency: with zero-wait memory and no stall, one instruction per cycle.
- Instruction at address A appears on instr_D one cycle after its ready cycle.
- First request starts 1 cycle after reset release.
- Reset asserted mid-request: immediate return to reset values. The outstanding memory request is abandoned, and memory must tolerate this.

Test Plan:
- Reset release, imem_ready tied 1, RESET_PC=0, memory[i]=i → imem_addr 0,4,8,… from cycle 1; instr_D=0,1,2 on consecutive cycles; valid_D=1.
- imem_ready=0 for 3 cycles at addr 8 → imem_addr stays 8, three bubbles (valid_D=0), then instr at 8 loads with PC_D=8.
- stall_D=1 for 2 cycles while ready=1 at addr 12 → instr_D holds addr-8 word, imem_req drops after capture; on release instr_D=word@12, PC_D=12, next request addr 16.
- PCSrc_M=1, PCBranch_M=0x100 with ready=1 → next imem_addr=0x100; valid_D=0 next cycle; word@0x100 follows.
- PCSrc_M=1 (target 0x200) while ready=0 at addr 0x20; ready after 2 cycles → imem_addr stays 0x20, word discarded, then imem_addr=0x200; no valid_D=1 for 0x20.
- PCSrc_M=1 with stall_D=1 and hold_valid=1 → hold discarded, valid_D=0, fetch resumes at target; reset pulse mid-request → all outputs 0, imem_addr=RESET_PC.
